// File: rtl/definitions_pkg.sv
// Shared HCB types: the instruction word carried through the instruction FIFO
// and the state encoding of the FIFO write-side arbiter.
package definitions_pkg;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [23:0] operand;
   } InstructionHCB;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} hcb_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N. When nothing is requested, o_winner echoes i_ptr.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_winner,
   output logic             o_found
);

   int w_idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      o_winner = i_ptr;
      o_found  = 1'b0;
      w_idx    = 0;
      // Walk from the farthest offset back to the pointer so the nearest request wins.
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = (int'(i_ptr) + k) % N;
         if (i_req[w_idx]) begin
            o_winner = IDX_W'(w_idx);
            o_found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hcb_instr_arbiter.sv
// Round-robin write-side arbiter in front of the InstructionHCB FIFO; groups
// closed by req_last are written contiguously by locking onto their owner.
module hcb_instr_arbiter
   import definitions_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = $bits(InstructionHCB),
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    srst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_last,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]       fifo_din,
   output logic                    fifo_wr_en,
   input  logic                    fifo_full,
   input  logic                    fifo_wr_rst_busy,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                    locked,
   output logic [CNT_W-1:0]        issued_cnt
);

   localparam int ID_W = $clog2(N_REQ);

   hcb_arb_state_e r_state, w_state_nxt;
   logic [ID_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
   logic [ID_W-1:0]  r_owner, w_owner_nxt;
   logic [CNT_W-1:0] r_issued_cnt;

   logic [ID_W-1:0] w_winner, w_sel, w_sel_inc;
   logic            w_found, w_can_wr, w_acc;

   rr_pick #(.N(N_REQ), .IDX_W(ID_W)) u_rr_pick (
      .i_req    (req_valid),
      .i_ptr    (r_rr_ptr),
      .o_winner (w_winner),
      .o_found  (w_found)
   );

   assign w_can_wr = ~fifo_full & ~fifo_wr_rst_busy & srst_n;
   assign w_sel    = (r_state == ARB_LOCKED) ? r_owner : w_winner;
   assign w_sel_inc = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + ID_W'(1);

   always_comb begin
      req_ready = '0;
      if (w_can_wr && ((r_state == ARB_LOCKED) || w_found))
         req_ready[w_sel] = 1'b1;
   end

   // Payload only feeds fifo_din, keeping req_data out of every control path.
   assign w_acc      = |(req_valid & req_ready);
   assign fifo_wr_en = w_acc;
   assign fifo_din   = req_data[int'(w_sel)*DATA_W +: DATA_W];
   assign grant_id   = w_sel;
   assign locked     = (r_state == ARB_LOCKED);
   assign issued_cnt = r_issued_cnt;

   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_owner_nxt  = r_owner;
      if (w_acc) begin
         if (req_last[w_sel]) begin
            w_state_nxt  = ARB_IDLE;
            w_rr_ptr_nxt = w_sel_inc;
         end else begin
            w_state_nxt = ARB_LOCKED;
            w_owner_nxt = w_sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!srst_n) begin
         r_state      <= ARB_IDLE;
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_issued_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_owner  <= w_owner_nxt;
         if (w_acc)
            r_issued_cnt <= r_issued_cnt + CNT_W'(1);
      end
   end

endmodule
